// File: rtl/tinyqv_peri_pkg.sv
// Shared register map and state encodings for the TinyQV UART peripheral.
package tinyqv_peri_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVIDER = 2'd2;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_FRM_ERR  = 4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO used for both the TX and RX byte queues.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count and pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tinyqv_uart_peri.sv
// 8N1 UART peripheral: DATA/STATUS/DIVIDER registers, TX and RX FIFOs, sticky error flags.
module tinyqv_uart_peri
  import tinyqv_peri_pkg::*;
#(
  parameter int CLK_HZ   = 64_000_000,
  parameter int BIT_RATE = 4_000_000,
  parameter int DIV_W    = 12,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  reg_addr,
  input  logic        reg_write,
  input  logic        reg_read,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_HZ / BIT_RATE - 1);
  localparam int LW = $clog2(TX_DEPTH) + 1;

  logic [DIV_W-1:0] divider;
  logic tx_ovf, rx_ovr, frm_err;

  logic wr_data, wr_status, wr_div, rd_data;
  assign wr_data   = reg_write && (reg_addr == ADDR_DATA);
  assign wr_status = reg_write && (reg_addr == ADDR_STATUS);
  assign wr_div    = reg_write && (reg_addr == ADDR_DIVIDER);
  assign rd_data   = reg_read  && (reg_addr == ADDR_DATA);

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:DIV_W]};

  // ---------------- TX path ----------------
  logic [7:0]    tx_head;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_room, tx_tick, tx_done;
  logic [LW-1:0] tx_level;
  uart_state_e   tx_state;
  logic [DIV_W-1:0] tx_cnt, tx_div;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;

  // The byte being shifted still occupies a slot, so software sees TX_DEPTH bytes of total buffering.
  assign tx_room = !tx_full && (tx_level != LW'(TX_DEPTH));
  assign tx_push = wr_data && tx_room;
  assign tx_tick = (tx_cnt == tx_div);
  assign tx_done = (tx_state == S_STOP) && tx_tick;
  assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) || tx_done);

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_level <= '0;
    end else if (tx_push && !tx_done) begin
      tx_level <= tx_level + 1'b1;
    end else if (!tx_push && tx_done) begin
      tx_level <= tx_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        S_IDLE: begin
          tx_cnt <= '0;
          if (!tx_empty) begin
            tx_state <= S_START;
            tx_shreg <= tx_head;
            tx_div   <= divider;
            uart_txd <= 1'b0;
          end
        end
        S_START: if (tx_tick) begin
          tx_state <= S_DATA;
          tx_bit   <= '0;
          uart_txd <= tx_shreg[0];
        end
        S_DATA: if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP;
            uart_txd <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            uart_txd <= tx_shreg[1];
          end
        end
        S_STOP: if (tx_tick) begin
          if (!tx_empty) begin
            tx_state <= S_START;
            tx_shreg <= tx_head;
            tx_div   <= divider;
            uart_txd <= 1'b0;
          end else begin
            tx_state <= S_IDLE;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]       rx_sync;
  logic             rx_s, rx_prev, rx_brk, rx_sample, rx_stop, rx_push;
  logic             rx_full, rx_empty;
  logic [7:0]       rx_head, rx_shreg;
  uart_state_e      rx_state;
  logic [DIV_W-1:0] rx_cnt, rx_div, rx_half;
  logic [2:0]       rx_bit;

  assign rx_s      = rx_sync[1];
  assign rx_sample = (rx_state == S_START) ? (rx_cnt == rx_half) : (rx_cnt == rx_div);
  assign rx_stop   = (rx_state == S_STOP) && !rx_brk && rx_sample;
  assign rx_push   = rx_stop && rx_s;

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rd_data), .din(rx_shreg),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_half  <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_brk   <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rxd};
      rx_prev <= rx_s;
      rx_cnt  <= rx_sample ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s) begin
            rx_state <= S_START;
            rx_div   <= divider;
            rx_half  <= DIV_W'(({1'b0, divider} + 1'b1) >> 1);
          end
        end
        S_START: if (rx_sample) begin
          rx_bit   <= '0;
          rx_state <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_sample) begin
          rx_shreg <= {rx_s, rx_shreg[7:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= S_STOP;
        end
        S_STOP: begin
          // A bad stop bit holds here until the line returns high, so a break is not seen as a new start.
          if (rx_brk) begin
            if (rx_s) begin
              rx_brk   <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_sample) begin
            if (rx_s) rx_state <= S_IDLE;
            else      rx_brk   <= 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- Registers ----------------
  logic [2:0] clr;
  assign clr = wr_status ? wdata[4:2] : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      divider <= DIV_RST;
      tx_ovf  <= 1'b0;
      rx_ovr  <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (wr_div) divider <= wdata[DIV_W-1:0];
      tx_ovf  <= (wr_data && !tx_room)    || (tx_ovf  && !clr[0]);
      rx_ovr  <= (rx_push && rx_full)     || (rx_ovr  && !clr[1]);
      frm_err <= (rx_stop && !rx_s)       || (frm_err && !clr[2]);
    end
  end

  assign irq = !rx_empty || tx_ovf || rx_ovr || frm_err;

  // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rdata = '0;
    case (reg_addr)
      ADDR_DATA:    rdata[7:0] = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: begin
        rdata[ST_TX_BUSY]  = !tx_empty || (tx_state != S_IDLE);
        rdata[ST_RX_VALID] = !rx_empty;
        rdata[ST_TX_OVF]   = tx_ovf;
        rdata[ST_RX_OVR]   = rx_ovr;
        rdata[ST_FRM_ERR]  = frm_err;
      end
      ADDR_DIVIDER: rdata = 32'(divider);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tinyqv_uart_peri.sv
// Scoreboard bench: register reads and decoded TX frames are checked against queued expectations.
module tb_tinyqv_uart_peri;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  reg_addr;
  logic        reg_write, reg_read;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        uart_txd;
  logic        uart_rxd;
  logic        irq;

  tinyqv_uart_peri dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
    .wdata(wdata), .rdata(rdata), .uart_txd(uart_txd), .uart_rxd(uart_rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  string       rd_name_q[$];
  logic [31:0] rd_val_q[$];
  logic [7:0]  tx_exp_q[$];

  int   tx_period   = 16;
  int   rst_count   = 0;
  logic mon_en      = 1'b0;
  logic tx_mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling clock edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a; wdata = d; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a; reg_read = 1'b1;
    rd_name_q.push_back(name);
    rd_val_q.push_back(exp);
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (8) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  always @(posedge clk) if (rst) rst_count <= rst_count + 1;

  // Read-side monitor: compares rdata in the middle of each read cycle.
  always @(negedge clk) begin
    #2;
    if (reg_read) begin
      if (rd_val_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_read: got 0x%0h expected none", rdata);
      end else begin
        check(rd_name_q.pop_front(), rdata, rd_val_q.pop_front());
      end
    end
  end

  // TX monitor: decodes frames on uart_txd, discarding any frame cut short by reset.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       start_ok, stop_ok;
    int         rst_snap;
    wait (mon_en);
    forever begin
      @(negedge uart_txd);
      tx_mon_busy = 1'b1;
      rst_snap = rst_count;
      repeat (tx_period / 2) @(negedge clk);
      start_ok = (uart_txd == 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (tx_period) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (tx_period) @(negedge clk);
      stop_ok = uart_txd;
      if (rst_count == rst_snap) begin
        if (tx_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected_frame: got 0x%0h expected none", b);
        end else begin
          check("tx_frame", {22'h0, stop_ok, start_ok, b}, {22'h0, 2'b11, tx_exp_q.pop_front()});
        end
      end
      tx_mon_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, t;
    rst = 1'b1; reg_addr = '0; reg_write = 1'b0; reg_read = 1'b0; wdata = '0; uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("txd_reset", {31'h0, uart_txd}, 32'h1);
    check("irq_reset", {31'h0, irq}, 32'h0);
    bus_read("status_reset", 2'd1, 32'h0);
    bus_read("divider_reset", 2'd2, 32'd15);
    bus_read("data_reset", 2'd0, 32'h0);
    bus_read("reserved_read", 2'd3, 32'h0);

    // Single frame 0x55 at 16 clocks per bit
    tx_exp_q.push_back(8'h55);
    bus_write(2'd0, 32'h55);
    fork
      begin
        n = 0; t = 0;
        while (uart_txd !== 1'b0 && t < 10) begin @(negedge clk); t++; end
        while (uart_txd === 1'b0 && n < 40) begin @(negedge clk); n++; end
        check("start_low_clocks", n, 16);
      end
      begin
        repeat (150) @(negedge clk);
        bus_read("tx_busy_mid", 2'd1, 32'h01);
        repeat (19) @(negedge clk);
        bus_read("tx_busy_clear", 2'd1, 32'h00);
      end
    join

    // Five back-to-back writes: four frames without gaps, fifth dropped
    for (int i = 1; i <= 4; i++) tx_exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i));
    repeat (626) @(negedge clk);
    bus_read("burst_busy", 2'd1, 32'h05);
    repeat (19) @(negedge clk);
    bus_read("burst_done_ovf", 2'd1, 32'h04);
    bus_write(2'd1, 32'h04);
    bus_read("tx_ovf_cleared", 2'd1, 32'h00);

    // RX single frame at divider 7
    bus_write(2'd2, 32'd7);
    bus_read("divider_7", 2'd2, 32'd7);
    send_byte(8'hA3, 1'b1);
    repeat (10) @(negedge clk);
    bus_read("rx_valid", 2'd1, 32'h02);
    check("irq_rx", {31'h0, irq}, 32'h1);
    bus_read("rx_a3", 2'd0, 32'hA3);
    bus_read("rx_drained", 2'd1, 32'h00);
    check("irq_drained", {31'h0, irq}, 32'h0);

    // RX overrun: five frames, first four kept in order
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    bus_read("rx_ovr_status", 2'd1, 32'h0A);
    bus_read("rx_q0", 2'd0, 32'h11);
    bus_read("rx_q1", 2'd0, 32'h22);
    bus_read("rx_q2", 2'd0, 32'h33);
    bus_read("rx_q3", 2'd0, 32'h44);
    bus_read("rx_empty_read", 2'd0, 32'h00);
    bus_read("rx_ovr_only", 2'd1, 32'h08);
    bus_write(2'd1, 32'h08);
    bus_read("rx_ovr_cleared", 2'd1, 32'h00);

    // Framing error, then glitch rejection, then recovery
    send_byte(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    bus_read("frm_err_status", 2'd1, 32'h10);
    check("irq_frm_err", {31'h0, irq}, 32'h1);
    bus_read("frm_err_no_data", 2'd0, 32'h00);
    bus_write(2'd1, 32'h10);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    bus_read("glitch_status", 2'd1, 32'h00);
    bus_read("glitch_data", 2'd0, 32'h00);
    send_byte(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    bus_read("rx_after_err", 2'd0, 32'h5A);

    // Reset in the middle of a TX frame
    tx_period = 8;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hF0);
    repeat (20) @(negedge clk);
    bus_read("pre_reset_status", 2'd1, 32'h05);
    check("txd_mid_frame_low", {31'h0, uart_txd}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("txd_after_reset", {31'h0, uart_txd}, 32'h1);
    rst = 1'b0;
    bus_read("status_after_reset", 2'd1, 32'h00);
    bus_read("divider_after_reset", 2'd2, 32'd15);
    check("irq_after_reset", {31'h0, irq}, 32'h0);
    repeat (30) @(negedge clk);
    check("txd_stays_idle", {31'h0, uart_txd}, 32'h1);

    t = 0;
    while (tx_mon_busy && t < 400) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check("tx_monitor_idle", {31'h0, tx_mon_busy}, 32'h0);
    check("tx_frames_outstanding", tx_exp_q.size(), 0);
    check("reads_outstanding", rd_val_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
